tow_referee: RTL and testbench

Round controller for Tug of War, placed directly upstream of the two per-player `tow_score` instances. It watches the playfield's edge-reached pulses and produces each scorer's one-cycle `increment` and its 2-bit `idle` freeze code. After every point it sequences a playfield re-centre and a hold-off window, and it latches game-over when either scorer reports `win`.

---
 rtl/tow_referee.sv | 94 +++++++++
 tb/tb_tow_referee.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tow_referee.sv
// Tug of War round controller: turns edge pulses into scorer increments, re-centre and hold-off, latches game over.
// Optional macro TOW_REF_AUTOSERVE_EN: HOLD exits on its own; otherwise a serve request is needed once the hold-off has expired.
module tow_referee #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edge_l,
    input  logic       edge_r,
    input  logic       win_l,
    input  logic       win_r,
    input  logic       serve,
    output logic       inc_l,
    output logic       inc_r,
    output logic [1:0] idle,
    output logic       field_reset,
    output logic [1:0] winner
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {PLAY, SCORE, HOLD, OVER} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
    logic          side_l, side_r, side_l_nxt, side_r_nxt;
    logic [1:0]    winner_nxt;
    logic          hold_done, go_play;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PLAY;
            cnt    <= '0;
            side_l <= 1'b0;
            side_r <= 1'b0;
            winner <= 2'b00;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            side_l <= side_l_nxt;
            side_r <= side_r_nxt;
            winner <= winner_nxt;
        end
    end

    // Hold-off ends on the cycle whose decremented count reaches zero,
    // giving exactly HOLD_CYCLES cycles of HOLD after the SCORE cycle.
    always_comb begin
        cnt_dec   = (cnt == '0) ? '0 : cnt - CW'(1);
        hold_done = (cnt_dec == '0);
`ifdef TOW_REF_AUTOSERVE_EN
        go_play   = hold_done;
`else
        go_play   = hold_done & serve;
`endif
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        side_l_nxt = side_l;
        side_r_nxt = side_r;
        winner_nxt = winner;
        case (state)
            PLAY: begin
                if (edge_l | edge_r) begin
                    state_nxt  = SCORE;
                    side_l_nxt = edge_l & ~edge_r;
                    side_r_nxt = edge_r & ~edge_l;
                end
            end
            SCORE: begin
                cnt_nxt   = CW'(HOLD_CYCLES);
                state_nxt = HOLD;
            end
            HOLD: begin
                cnt_nxt = cnt_dec;
                if (go_play) state_nxt = PLAY;
            end
            default: state_nxt = OVER;
        endcase
        // A win pre-empts everything, including a pending point.
        if (state != OVER && (win_l | win_r)) begin
            state_nxt  = OVER;
            winner_nxt = win_l ? 2'b01 : 2'b10;
        end
    end

    assign inc_l       = (state == SCORE) & side_l;
    assign inc_r       = (state == SCORE) & side_r;
    assign field_reset = (state == SCORE);
    assign idle        = {state == OVER, state == HOLD};

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: points, ties, hold-off, wins, serve gating.
module tb_tow_referee;

    logic       clk = 1'b0;
    logic       reset, edge_l, edge_r, win_l, win_r, serve;
    logic       inc_l, inc_r, field_reset;
    logic [1:0] idle, winner;
    int         n_checks = 0;
    int         n_fail = 0;

    tow_referee #(.HOLD_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .edge_l(edge_l), .edge_r(edge_r),
        .win_l(win_l), .win_r(win_r), .serve(serve),
        .inc_l(inc_l), .inc_r(inc_r), .idle(idle),
        .field_reset(field_reset), .winner(winner)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; edge_l = 0; edge_r = 0; win_l = 0; win_r = 0; serve = 1;
        tick(); tick();
        n_checks++;
        if ({inc_l, inc_r, field_reset, idle, winner} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000", {inc_l, inc_r, field_reset, idle, winner});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (idle !== 2'b00) begin n_fail++; $display("FAIL reset_play_idle: got %b expected 00", idle); end
    endtask

    task automatic test_left_point();
        edge_l = 1; tick(); edge_l = 0;
        n_checks++;
        if ({inc_l, inc_r, field_reset, idle} !== 5'b10100) begin
            n_fail++;
            $display("FAIL left_score: got {inc_l,inc_r,fr,idle}=%b expected 10100", {inc_l, inc_r, field_reset, idle});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({inc_l, inc_r, field_reset, idle} !== 5'b00001) begin
                n_fail++;
                $display("FAIL left_hold[%0d]: got %b expected 00001", i, {inc_l, inc_r, field_reset, idle});
            end
        end
        tick();
        n_checks++;
        if (idle !== 2'b00) begin n_fail++; $display("FAIL left_back_to_play: got idle %b expected 00", idle); end
    endtask

    task automatic test_tie();
        edge_l = 1; edge_r = 1; tick(); edge_l = 0; edge_r = 0;
        n_checks++;
        if ({inc_l, inc_r, field_reset, idle} !== 5'b00100) begin
            n_fail++;
            $display("FAIL tie_score: got %b expected 00100", {inc_l, inc_r, field_reset, idle});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (idle !== 2'b01) begin n_fail++; $display("FAIL tie_hold[%0d]: got idle %b expected 01", i, idle); end
        end
        tick();
        n_checks++;
        if (idle !== 2'b00) begin n_fail++; $display("FAIL tie_back_to_play: got idle %b expected 00", idle); end
    endtask

    task automatic test_edge_during_hold();
        edge_l = 1; tick(); edge_l = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            edge_r = (i == 2);
            n_checks++;
            if ({inc_r, field_reset, idle} !== 4'b0001) begin
                n_fail++;
                $display("FAIL hold_edge[%0d]: got {inc_r,fr,idle}=%b expected 0001", i, {inc_r, field_reset, idle});
            end
        end
        edge_r = 0;
        tick();
        n_checks++;
        if ({inc_r, idle} !== 3'b000) begin n_fail++; $display("FAIL hold_edge_exit: got %b expected 000", {inc_r, idle}); end
        tick();
        n_checks++;
        if ({inc_r, field_reset} !== 2'b00) begin n_fail++; $display("FAIL hold_edge_ignored: got %b expected 00", {inc_r, field_reset}); end
    endtask

    // Continuous edge: pulses on cycles 1, 11, 21 only, never adjacent.
    task automatic test_back_to_back();
        int pulses = 0;
        logic prev = 0;
        int adj = 0;
        edge_r = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (inc_r) pulses++;
            if (inc_r && prev) adj++;
            prev = inc_r;
        end
        edge_r = 0;
        n_checks++;
        if (pulses !== 3) begin n_fail++; $display("FAIL held_edge_rate: got %0d pulses expected 3", pulses); end
        n_checks++;
        if (adj !== 0) begin n_fail++; $display("FAIL held_edge_adjacent: got %0d expected 0", adj); end
        do_reset();
    endtask

    task automatic test_win_in_hold();
        edge_l = 1; tick(); edge_l = 0;
        tick(); tick();
        win_r = 1; tick(); win_r = 0;
        n_checks++;
        if ({idle, winner} !== 4'b1010) begin n_fail++; $display("FAIL win_r: got {idle,winner}=%b expected 1010", {idle, winner}); end
        edge_l = 1; serve = 1; win_l = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            serve = ~serve;
            n_checks++;
            if ({inc_l, field_reset, idle, winner} !== 6'b001010) begin
                n_fail++;
                $display("FAIL over_sticky[%0d]: got %b expected 001010", i, {inc_l, field_reset, idle, winner});
            end
        end
        edge_l = 0; win_l = 0; serve = 1;
        do_reset();
        n_checks++;
        if ({idle, winner} !== 4'b0000) begin n_fail++; $display("FAIL over_reset: got %b expected 0000", {idle, winner}); end
    endtask

    task automatic test_double_win();
        win_l = 1; win_r = 1; edge_r = 1; tick(); win_l = 0; win_r = 0; edge_r = 0;
        n_checks++;
        if ({inc_r, field_reset, idle, winner} !== 6'b001001) begin
            n_fail++;
            $display("FAIL double_win: got %b expected 001001", {inc_r, field_reset, idle, winner});
        end
        do_reset();
    endtask

    task automatic test_serve_gating();
        serve = 0;
        edge_l = 1; tick(); edge_l = 0;
`ifdef TOW_REF_AUTOSERVE_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (idle !== 2'b01) begin n_fail++; $display("FAIL auto_hold[%0d]: got %b expected 01", i, idle); end
        end
        tick();
        n_checks++;
        if (idle !== 2'b00) begin n_fail++; $display("FAIL auto_exit: got %b expected 00", idle); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (idle !== 2'b01) begin n_fail++; $display("FAIL serve_wait[%0d]: got %b expected 01", i, idle); end
        end
        serve = 1;
        tick();
        n_checks++;
        if (idle !== 2'b00) begin n_fail++; $display("FAIL serve_exit: got %b expected 00", idle); end
`endif
        serve = 1;
    endtask

    initial begin
        test_reset();
        test_left_point();
        test_tie();
        test_edge_during_hold();
        test_back_to_back();
        test_win_in_hold();
        test_double_win();
        test_serve_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
